// File: rtl/rv_pkg.sv
// Shared RISC-V control-flow encodings used by the execute-stage redirect logic.
package rv_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_funct3_t;

endpackage

// File: rtl/branch_redirect_cmp.sv
// Conditional-branch comparator: evaluates funct3 against two operands and flags
// whether funct3 names a real branch condition.
module branch_cmp
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  cond_o,
  output logic                  valid_f3_o
);

  logic eq_s;
  logic lt_s;
  logic ltu_s;

  assign eq_s  = (a_i == b_i);
  assign lt_s  = ($signed(a_i) < $signed(b_i));
  assign ltu_s = (a_i < b_i);

  // funct3 010/011 are reserved on the branch opcode: never taken, never counted
  always_comb begin
    cond_o     = 1'b0;
    valid_f3_o = 1'b1;
    case (br_funct3_t'(funct3_i))
      BEQ:     cond_o = eq_s;
      BNE:     cond_o = ~eq_s;
      BLT:     cond_o = lt_s;
      BGE:     cond_o = ~lt_s;
      BLTU:    cond_o = ltu_s;
      BGEU:    cond_o = ~ltu_s;
      default: begin
        cond_o     = 1'b0;
        valid_f3_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_redirect.sv
// Execute-stage branch/jump resolution: owns the D->E pipeline register, drives the
// fetch redirect and decode flush, and keeps saturating branch statistics.
module branch_redirect
  import rv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] InstrD,
  input  logic [DATA_WIDTH-1:0] PCd,
  input  logic [DATA_WIDTH-1:0] PCPlus4D,
  input  logic                  BubbleE,
  input  logic [DATA_WIDTH-1:0] SrcAE,
  input  logic [DATA_WIDTH-1:0] SrcBE,
  output logic [4:0]            Rs1E,
  output logic [4:0]            Rs2E,
  output logic                  PCsrcE,
  output logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  FlushD,
  output logic [DATA_WIDTH-1:0] LinkE,
  output logic                  MisalignE,
  output logic [CNT_WIDTH-1:0]  BranchCnt,
  output logic [CNT_WIDTH-1:0]  TakenCnt
);

  localparam logic [DATA_WIDTH-1:0] NOP_W   = DATA_WIDTH'(NOP_INSTR);
  localparam logic [DATA_WIDTH-1:0] ZERO_W  = '0;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

  logic [DATA_WIDTH-1:0] InstrE_q, InstrE_d;
  logic [DATA_WIDTH-1:0] PCe_q, PCe_d;
  logic [DATA_WIDTH-1:0] PCPlus4E_q, PCPlus4E_d;
  logic                  ValidE_q, ValidE_d;
  logic [CNT_WIDTH-1:0]  BranchCnt_q, BranchCnt_d;
  logic [CNT_WIDTH-1:0]  TakenCnt_q, TakenCnt_d;

  logic [6:0]            opcode_s;
  logic                  is_branch_s;
  logic                  is_jal_s;
  logic                  is_jalr_s;
  logic [DATA_WIDTH-1:0] imm_b_s;
  logic [DATA_WIDTH-1:0] imm_j_s;
  logic [DATA_WIDTH-1:0] imm_i_s;
  logic [DATA_WIDTH-1:0] pc_off_s;
  logic [DATA_WIDTH-1:0] jalr_sum_s;
  logic [DATA_WIDTH-1:0] target_s;
  logic                  cond_s;
  logic                  valid_f3_s;
  logic                  taken_s;
  logic                  misalign_s;
  logic                  redirect_s;
  logic                  count_en_s;

  assign opcode_s    = InstrE_q[6:0];
  assign is_branch_s = (opcode_s == OPC_BRANCH);
  assign is_jal_s    = (opcode_s == OPC_JAL);
  assign is_jalr_s   = (opcode_s == OPC_JALR);

  assign imm_b_s = {{(DATA_WIDTH-12){InstrE_q[31]}}, InstrE_q[7], InstrE_q[30:25],
                    InstrE_q[11:8], 1'b0};
  assign imm_j_s = {{(DATA_WIDTH-20){InstrE_q[31]}}, InstrE_q[19:12], InstrE_q[20],
                    InstrE_q[30:21], 1'b0};
  assign imm_i_s = {{(DATA_WIDTH-12){InstrE_q[31]}}, InstrE_q[31:20]};

  branch_cmp #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cmp (
    .funct3_i   (InstrE_q[14:12]),
    .a_i        (SrcAE),
    .b_i        (SrcBE),
    .cond_o     (cond_s),
    .valid_f3_o (valid_f3_s)
  );

  // Target generation; arithmetic wraps modulo 2^DATA_WIDTH by construction
  always_comb begin
    pc_off_s   = is_jal_s ? imm_j_s : imm_b_s;
    jalr_sum_s = SrcAE + imm_i_s;
    if (is_jalr_s) begin
      target_s = {jalr_sum_s[DATA_WIDTH-1:1], 1'b0};
    end else begin
      target_s = PCe_q + pc_off_s;
    end
  end

  // A misaligned taken target is reported but never redirects fetch
  assign taken_s    = is_jal_s | is_jalr_s | (is_branch_s & valid_f3_s & cond_s);
  assign misalign_s = taken_s & ValidE_q & (target_s[1] | target_s[0]);
  assign redirect_s = taken_s & ValidE_q & ~misalign_s;
  assign count_en_s = ValidE_q & is_branch_s & valid_f3_s;

  assign Rs1E      = InstrE_q[19:15];
  assign Rs2E      = InstrE_q[24:20];
  assign PCsrcE    = redirect_s;
  assign FlushD    = redirect_s;
  assign PCTargetE = ValidE_q ? target_s : ZERO_W;
  assign MisalignE = misalign_s;
  assign LinkE     = PCPlus4E_q;
  assign BranchCnt = BranchCnt_q;
  assign TakenCnt  = TakenCnt_q;

  // E register next state: wrong-path or load-use slots become an invalid NOP
  always_comb begin
    InstrE_d   = InstrD;
    PCe_d      = PCd;
    PCPlus4E_d = PCPlus4D;
    ValidE_d   = 1'b1;
    if (redirect_s || BubbleE) begin
      InstrE_d   = NOP_W;
      PCe_d      = ZERO_W;
      PCPlus4E_d = ZERO_W;
      ValidE_d   = 1'b0;
    end else begin
      ValidE_d   = 1'b1;
    end
  end

  // Saturating statistics; misaligned taken branches still count
  always_comb begin
    BranchCnt_d = BranchCnt_q;
    TakenCnt_d  = TakenCnt_q;
    if (count_en_s) begin
      if (BranchCnt_q != CNT_MAX) begin
        BranchCnt_d = BranchCnt_q + CNT_ONE;
      end else begin
        BranchCnt_d = BranchCnt_q;
      end
      if (cond_s && (TakenCnt_q != CNT_MAX)) begin
        TakenCnt_d = TakenCnt_q + CNT_ONE;
      end else begin
        TakenCnt_d = TakenCnt_q;
      end
    end else begin
      BranchCnt_d = BranchCnt_q;
      TakenCnt_d  = TakenCnt_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      InstrE_q    <= NOP_W;
      PCe_q       <= ZERO_W;
      PCPlus4E_q  <= ZERO_W;
      ValidE_q    <= 1'b0;
      BranchCnt_q <= '0;
      TakenCnt_q  <= '0;
    end else begin
      InstrE_q    <= InstrE_d;
      PCe_q       <= PCe_d;
      PCPlus4E_q  <= PCPlus4E_d;
      ValidE_q    <= ValidE_d;
      BranchCnt_q <= BranchCnt_d;
      TakenCnt_q  <= TakenCnt_d;
    end
  end

endmodule

// File: tb/tb_branch_redirect.sv
// Directed bench for branch_redirect: table of single-instruction vectors plus
// hand-written sequences for reset, bubbles and counter saturation.
module tb_branch_redirect;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCd, PCPlus4D, SrcAE, SrcBE;
  logic        BubbleE;
  logic [4:0]  Rs1E, Rs2E;
  logic        PCsrcE, FlushD, MisalignE;
  logic [31:0] PCTargetE, LinkE;
  logic [15:0] BranchCnt, TakenCnt;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] ADDI  = 32'h00500093;
  localparam logic [31:0] PROBE_PC = 32'h00000A00;

  branch_redirect #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCd(PCd), .PCPlus4D(PCPlus4D),
    .BubbleE(BubbleE), .SrcAE(SrcAE), .SrcBE(SrcBE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .PCsrcE(PCsrcE), .PCTargetE(PCTargetE), .FlushD(FlushD), .LinkE(LinkE),
    .MisalignE(MisalignE), .BranchCnt(BranchCnt), .TakenCnt(TakenCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic        pcsrc;
    logic        mis;
    logic        chk_tgt;
    logic [31:0] tgt;
    logic [15:0] bcnt;
    logic [15:0] tcnt;
  } vec_t;

  vec_t vt[14];

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic [31:0] instr, input logic [31:0] pc);
    InstrD   = instr;
    PCd      = pc;
    PCPlus4D = pc + 32'd4;
  endtask

  initial begin
    vt[0]  = '{enc_b(3'b000, 5'd1, 5'd2, 13'd16),   32'h100, 32'd5, 32'd5,
               1'b1, 1'b0, 1'b1, 32'h110, 16'd1, 16'd1};
    vt[1]  = '{enc_b(3'b001, 5'd1, 5'd2, 13'd16),   32'h100, 32'd5, 32'd5,
               1'b0, 1'b0, 1'b1, 32'h110, 16'd2, 16'd1};
    vt[2]  = '{enc_b(3'b100, 5'd3, 5'd4, 13'd32),   32'h200, 32'hFFFFFFFF, 32'd1,
               1'b1, 1'b0, 1'b1, 32'h220, 16'd3, 16'd2};
    vt[3]  = '{enc_b(3'b110, 5'd3, 5'd4, 13'd32),   32'h200, 32'hFFFFFFFF, 32'd1,
               1'b0, 1'b0, 1'b1, 32'h220, 16'd4, 16'd2};
    vt[4]  = '{enc_b(3'b101, 5'd5, 5'd6, -13'sd16), 32'h300, 32'd1, 32'hFFFFFFFF,
               1'b1, 1'b0, 1'b1, 32'h2F0, 16'd5, 16'd3};
    vt[5]  = '{enc_b(3'b111, 5'd5, 5'd6, -13'sd16), 32'h300, 32'd1, 32'hFFFFFFFF,
               1'b0, 1'b0, 1'b1, 32'h2F0, 16'd6, 16'd3};
    vt[6]  = '{enc_jalr(5'd1, 5'd7, 12'd0),         32'h400, 32'h203, 32'd0,
               1'b0, 1'b1, 1'b1, 32'h202, 16'd6, 16'd3};
    vt[7]  = '{enc_j(5'd1, -21'sd8),                32'h004, 32'd0, 32'd0,
               1'b1, 1'b0, 1'b1, 32'hFFFFFFFC, 16'd6, 16'd3};
    vt[8]  = '{enc_b(3'b010, 5'd1, 5'd2, 13'd16),   32'h500, 32'd0, 32'd0,
               1'b0, 1'b0, 1'b1, 32'h510, 16'd6, 16'd3};
    vt[9]  = '{enc_b(3'b000, 5'd1, 5'd2, 13'd2),    32'h600, 32'd7, 32'd7,
               1'b0, 1'b1, 1'b1, 32'h602, 16'd7, 16'd4};
    vt[10] = '{enc_jalr(5'd1, 5'd8, 12'h011),       32'h700, 32'h1000, 32'd0,
               1'b1, 1'b0, 1'b1, 32'h1010, 16'd7, 16'd4};
    vt[11] = '{ADDI,                                32'h800, 32'd0, 32'd0,
               1'b0, 1'b0, 1'b0, 32'h0, 16'd7, 16'd4};
    vt[12] = '{enc_b(3'b110, 5'd1, 5'd2, 13'd8),    32'h900, 32'd1, 32'd2,
               1'b1, 1'b0, 1'b1, 32'h908, 16'd8, 16'd5};
    vt[13] = '{enc_b(3'b001, 5'd1, 5'd2, -13'sd4),  32'h010, 32'd9, 32'd3,
               1'b1, 1'b0, 1'b1, 32'h00C, 16'd9, 16'd6};

    rst = 1'b1; BubbleE = 1'b0; SrcAE = '0; SrcBE = '0;
    drive_d(vt[0].instr, 32'h100);
    step(); step();
    rst = 1'b0;
    drive_d(NOP, 32'h0);
    chk("rst_pcsrc",  {31'd0, PCsrcE}, 32'd0);
    chk("rst_flushd", {31'd0, FlushD}, 32'd0);
    chk("rst_rs1rs2", {22'd0, Rs1E, Rs2E}, 32'd0);
    chk("rst_link",   LinkE, 32'd0);
    chk("rst_target", PCTargetE, 32'd0);
    chk("rst_bcnt",   {16'd0, BranchCnt}, 32'd0);
    chk("rst_tcnt",   {16'd0, TakenCnt}, 32'd0);
    step();

    // Per vector: load into E and check resolution, then a taken JAL probe that
    // must be bubbled exactly when the vector redirected, then a NOP spacer.
    for (int i = 0; i < 14; i++) begin
      drive_d(vt[i].instr, vt[i].pc);
      step();
      SrcAE = vt[i].a; SrcBE = vt[i].b;
      #1;
      chk($sformatf("v%0d_pcsrc", i), {31'd0, PCsrcE}, {31'd0, vt[i].pcsrc});
      chk($sformatf("v%0d_flushd", i), {31'd0, FlushD}, {31'd0, vt[i].pcsrc});
      chk($sformatf("v%0d_misalign", i), {31'd0, MisalignE}, {31'd0, vt[i].mis});
      chk($sformatf("v%0d_link", i), LinkE, vt[i].pc + 32'd4);
      if (vt[i].chk_tgt) chk($sformatf("v%0d_target", i), PCTargetE, vt[i].tgt);
      drive_d(enc_j(5'd0, 21'd8), PROBE_PC);
      step();
      chk($sformatf("v%0d_bcnt", i), {16'd0, BranchCnt}, {16'd0, vt[i].bcnt});
      chk($sformatf("v%0d_tcnt", i), {16'd0, TakenCnt}, {16'd0, vt[i].tcnt});
      chk($sformatf("v%0d_probe", i), {31'd0, PCsrcE}, {31'd0, ~vt[i].pcsrc});
      drive_d(NOP, 32'h0);
      step();
    end

    // Load-use bubble swallows a taken BEQ sitting in D
    drive_d(vt[0].instr, 32'h100);
    SrcAE = 32'd5; SrcBE = 32'd5; BubbleE = 1'b1;
    step();
    BubbleE = 1'b0;
    drive_d(NOP, 32'h0);
    chk("bub_pcsrc", {31'd0, PCsrcE}, 32'd0);
    chk("bub_target", PCTargetE, 32'd0);
    step();
    chk("bub_pcsrc2", {31'd0, PCsrcE}, 32'd0);
    chk("bub_bcnt", {16'd0, BranchCnt}, 32'd9);

    // Redirect and BubbleE together: the following slot is still a single bubble
    drive_d(vt[0].instr, 32'h100);
    step();
    chk("rb_pcsrc", {31'd0, PCsrcE}, 32'd1);
    drive_d(enc_j(5'd0, 21'd8), PROBE_PC);
    BubbleE = 1'b1;
    step();
    BubbleE = 1'b0;
    drive_d(NOP, 32'h0);
    chk("rb_bubble", {31'd0, PCsrcE}, 32'd0);
    chk("rb_link", LinkE, 32'd0);
    step();

    // Reset while a taken branch sits in E
    drive_d(vt[0].instr, 32'h100);
    step();
    chk("mid_pre", {31'd0, PCsrcE}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive_d(NOP, 32'h0);
    chk("mid_pcsrc", {31'd0, PCsrcE}, 32'd0);
    chk("mid_bcnt", {16'd0, BranchCnt}, 32'd0);
    chk("mid_tcnt", {16'd0, TakenCnt}, 32'd0);
    chk("mid_link", LinkE, 32'd0);

    // Saturation: a misaligned taken BEQ never redirects, so it counts every cycle
    drive_d(enc_b(3'b000, 5'd1, 5'd2, 13'd2), 32'h600);
    SrcAE = 32'd0; SrcBE = 32'd0;
    for (int k = 0; k < 101; k++) step();
    chk("sat_bcnt_100", {16'd0, BranchCnt}, 32'd100);
    chk("sat_tcnt_100", {16'd0, TakenCnt}, 32'd100);
    for (int k = 0; k < 65539 - 100; k++) step();
    chk("sat_bcnt", {16'd0, BranchCnt}, 32'h0000FFFF);
    chk("sat_tcnt", {16'd0, TakenCnt}, 32'h0000FFFF);
    chk("sat_pcsrc", {31'd0, PCsrcE}, 32'd0);
    chk("sat_misalign", {31'd0, MisalignE}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
